sys_irq_aggregator: RTL and testbench

// Interrupt aggregator that sits directly downstream of sys_clk_timer and the other

---
 rtl/sys_irq_aggregator.sv | 178 +++++++++++++++++
 tb/tb_sys_irq_aggregator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_irq_aggregator.sv
// sys_irq_aggregator
//   Collects raw interrupt lines from the Avalon-MM peripherals. Each source is
//   either level-following or rising-edge latched. Firmware can mask each source.
//   The block drives one registered irq and the index of the highest-priority
//   active source. Index 0 has the highest priority.
// Ports
//   clk, reset       system clock, asynchronous active-high reset
//   chipselect,
//   address,
//   write_n,
//   writedata        Avalon-MM slave write side (16-bit data, 3-bit word address)
//   readdata         registered read data, 1-cycle latency, no wait states
//   irq_src          raw interrupt inputs, active high
//   irq, irq_id      aggregated interrupt and {valid, index[3:0]}, registered
// Register map
//   0 PENDING (R/W1C)  1 ENABLE (RW)  2 EDGE_MODE (RW)  3 ACTIVE_ID (R)
//   4 RAW (R)          5 SET (W, reads 0)               6,7 reserved
module sys_irq_aggregator #(
  parameter int unsigned NUM_SRC        = 8,
  parameter int unsigned SYNC_STAGES    = 0,
  parameter logic [15:0] DEFAULT_ENABLE = 16'h0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chipselect,
  input  logic [2:0]         address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq,
  output logic [4:0]         irq_id
);

  localparam logic [2:0] AddrPending  = 3'd0;
  localparam logic [2:0] AddrEnable   = 3'd1;
  localparam logic [2:0] AddrEdgeMode = 3'd2;
  localparam logic [2:0] AddrActiveId = 3'd3;
  localparam logic [2:0] AddrRaw      = 3'd4;
  localparam logic [2:0] AddrSet      = 3'd5;

  // Internal state is kept 16 bits wide. Bits at or above NUM_SRC are forced to zero,
  // so they read back as 0 and writes to them have no effect.
  localparam logic [15:0] SrcMask = 16'hFFFF >> (16 - NUM_SRC);

  logic [15:0] src_raw;
  logic [15:0] src_s;

  assign src_raw = 16'(irq_src);

  // Input synchroniser: SYNC_STAGES flops per source, or a straight wire when 0.
  if (SYNC_STAGES == 0) begin : g_no_sync
    assign src_s = src_raw;
  end else begin : g_sync
    logic [15:0] sync_q [SYNC_STAGES];
    logic [15:0] sync_d [SYNC_STAGES];

    always_comb begin
      sync_d[0] = src_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_d[k] = sync_q[k-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          sync_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_d[k];
        end
      end
    end

    assign src_s = sync_q[SYNC_STAGES-1];
  end

  logic [15:0] pending_q,   pending_d;
  logic [15:0] enable_q,    enable_d;
  logic [15:0] edge_mode_q, edge_mode_d;
  logic [15:0] prev_q,      prev_d;
  logic [15:0] readdata_q,  readdata_d;
  logic        irq_q,       irq_d;
  logic [4:0]  irq_id_q,    irq_id_d;

  logic        wr_en;
  logic [15:0] wdata_src;
  logic [15:0] edge_det;
  logic [15:0] w1c;
  logic [15:0] set_bits;
  logic [15:0] mode_chg;
  logic [15:0] active;

  assign wr_en     = chipselect & ~write_n;
  assign wdata_src = writedata & SrcMask;

  // Register writes and pending update.
  always_comb begin
    enable_d    = enable_q;
    edge_mode_d = edge_mode_q;
    prev_d      = src_s;
    edge_det    = src_s & ~prev_q;
    w1c         = '0;
    set_bits    = '0;
    mode_chg    = '0;

    if (wr_en) begin
      case (address)
        AddrPending:  w1c      = wdata_src;
        AddrEnable:   enable_d = wdata_src;
        AddrEdgeMode: begin
          edge_mode_d = wdata_src;
          mode_chg    = wdata_src ^ edge_mode_q;
        end
        AddrSet:      set_bits = wdata_src;
        default:      ;
      endcase
    end

    // Edge bits: a new edge or SET outranks a same-cycle W1C, so no event is lost.
    // Level bits simply follow the synchronised input.
    // A mode switch discards whatever was pending under the old mode.
    pending_d = ((edge_mode_q & (edge_det | set_bits | (pending_q & ~w1c)))
                | (~edge_mode_q & src_s)) & ~mode_chg & SrcMask;
  end

  // Aggregation and fixed-priority encode (lowest index wins).
  always_comb begin
    active   = pending_q & enable_q;
    irq_d    = |active;
    irq_id_d = '0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) begin
        irq_id_d = {1'b1, 4'(i)};
      end
    end
  end

  // Read mux is sampled every cycle, whatever the state of chipselect.
  always_comb begin
    readdata_d = '0;
    case (address)
      AddrPending:  readdata_d = pending_q;
      AddrEnable:   readdata_d = enable_q;
      AddrEdgeMode: readdata_d = edge_mode_q;
      AddrActiveId: readdata_d = {11'b0, irq_id_q};
      AddrRaw:      readdata_d = src_s;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      enable_q    <= DEFAULT_ENABLE & SrcMask;
      edge_mode_q <= '0;
      prev_q      <= '0;
      readdata_q  <= '0;
      irq_q       <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      edge_mode_q <= edge_mode_d;
      prev_q      <= prev_d;
      readdata_q  <= readdata_d;
      irq_q       <= irq_d;
      irq_id_q    <= irq_id_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;
  assign irq_id   = irq_id_q;

endmodule

// File: tb/tb_sys_irq_aggregator.sv
// Bench for sys_irq_aggregator.
// The main instance has NUM_SRC=8, SYNC_STAGES=0 and DEFAULT_ENABLE=0x00A5.
// A second instance with SYNC_STAGES=2 checks the added input latency.
// Expected read values are queued when a read is issued.
// They are popped and compared once readdata is valid.
module tb_sys_irq_aggregator;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [7:0]  irq_src;
  logic        irq;
  logic [4:0]  irq_id;

  logic        cs_b;
  logic [2:0]  addr_b;
  logic        wn_b;
  logic [15:0] wd_b;
  logic [15:0] rd_b;
  logic [7:0]  src_b;
  logic        irq_b;
  logic [4:0]  irq_id_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [15:0] value;
  } exp_t;

  typedef struct {
    bit          is_write;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[19];

  always #5 clk = ~clk;

  sys_irq_aggregator #(
    .NUM_SRC       (8),
    .SYNC_STAGES   (0),
    .DEFAULT_ENABLE(16'h00A5)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chipselect(chipselect),
    .address   (address),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .irq_src   (irq_src),
    .irq       (irq),
    .irq_id    (irq_id)
  );

  sys_irq_aggregator #(
    .NUM_SRC       (8),
    .SYNC_STAGES   (2),
    .DEFAULT_ENABLE(16'h0001)
  ) dut_sync (
    .clk       (clk),
    .reset     (reset),
    .chipselect(cs_b),
    .address   (addr_b),
    .write_n   (wn_b),
    .writedata (wd_b),
    .readdata  (rd_b),
    .irq_src   (src_b),
    .irq       (irq_b),
    .irq_id    (irq_id_b)
  );

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [15:0] e, input string name);
    exp_t x;
    exp_t y;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    x.name     = name;
    x.value    = e;
    sb_q.push_back(x);
    step();
    chipselect = 1'b0;
    y = sb_q.pop_front();
    check(y.name, readdata, y.value);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{1'b0, 3'd1, 16'h0000, 16'h00A5, "rst_enable"},
      '{1'b0, 3'd0, 16'h0000, 16'h0000, "rst_pending"},
      '{1'b0, 3'd2, 16'h0000, 16'h0000, "rst_edge_mode"},
      '{1'b0, 3'd3, 16'h0000, 16'h0000, "rst_active_id"},
      '{1'b0, 3'd4, 16'h0000, 16'h0000, "rst_raw"},
      '{1'b0, 3'd5, 16'h0000, 16'h0000, "rst_set_reads0"},
      '{1'b1, 3'd1, 16'hFFFF, 16'h0000, ""},
      '{1'b0, 3'd1, 16'h0000, 16'h00FF, "enable_upper_ignored"},
      '{1'b1, 3'd2, 16'hFF0F, 16'h0000, ""},
      '{1'b0, 3'd2, 16'h0000, 16'h000F, "edge_mode_upper_ignored"},
      '{1'b1, 3'd2, 16'h0000, 16'h0000, ""},
      '{1'b0, 3'd2, 16'h0000, 16'h0000, "edge_mode_clear"},
      '{1'b1, 3'd6, 16'hFFFF, 16'h0000, ""},
      '{1'b0, 3'd6, 16'h0000, 16'h0000, "reserved6"},
      '{1'b0, 3'd7, 16'h0000, 16'h0000, "reserved7"},
      '{1'b1, 3'd5, 16'h00FF, 16'h0000, ""},
      '{1'b0, 3'd0, 16'h0000, 16'h0000, "set_level_ignored"},
      '{1'b1, 3'd1, 16'h0000, 16'h0000, ""},
      '{1'b0, 3'd1, 16'h0000, 16'h0000, "enable_zero"}
    };

    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = '0;
    irq_src    = '0;
    cs_b       = 1'b0;
    addr_b     = 3'd0;
    wn_b       = 1'b1;
    wd_b       = '0;
    src_b      = '0;
    step(2);
    check("reset_readdata", readdata, 16'h0000);
    check("reset_irq", 16'(irq), 16'h0000);
    check("reset_irq_id", 16'(irq_id), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Register-level vectors.
    for (int i = 0; i < $size(tbl); i++) begin
      if (tbl[i].is_write) bus_write(tbl[i].addr, tbl[i].data);
      else                 bus_read(tbl[i].addr, tbl[i].exp, tbl[i].name);
    end

    // Two synchroniser stages: irq at t+4.
    src_b[0] = 1'b1;
    step(3);
    check("sync2_irq_t3", 16'(irq_b), 16'h0000);
    step();
    check("sync2_irq_t4", 16'(irq_b), 16'h0001);
    check("sync2_irq_id_t4", 16'(irq_id_b), 16'h0010);
    check("sync2_pending", rd_b, 16'h0001);

    // Level source 0.
    bus_write(3'd1, 16'h0001);
    irq_src[0] = 1'b1;
    step();
    check("level_irq_t1", 16'(irq), 16'h0000);
    step();
    check("level_irq_t2", 16'(irq), 16'h0001);
    check("level_irq_id_t2", 16'(irq_id), 16'h0010);
    bus_write(3'd0, 16'h0001);
    bus_read(3'd0, 16'h0001, "level_w1c_ignored");
    irq_src[0] = 1'b0;
    step();
    check("level_fall_t1", 16'(irq), 16'h0001);
    step();
    check("level_fall_t2", 16'(irq), 16'h0000);
    check("level_fall_id", 16'(irq_id), 16'h0000);

    // Edge source 2, single-cycle pulse.
    bus_write(3'd2, 16'h0004);
    bus_write(3'd1, 16'h0004);
    irq_src[2] = 1'b1;
    step();
    irq_src[2] = 1'b0;
    step();
    check("edge_irq", 16'(irq), 16'h0001);
    check("edge_irq_id", 16'(irq_id), 16'h0012);
    step(3);
    bus_read(3'd0, 16'h0004, "edge_pending_held");
    bus_write(3'd0, 16'h0004);
    check("edge_irq_before_clear", 16'(irq), 16'h0001);
    step();
    check("edge_irq_cleared", 16'(irq), 16'h0000);

    // Edge arriving in the same cycle as W1C of the same bit.
    irq_src[2] = 1'b1;
    step();
    irq_src[2] = 1'b0;
    step(2);
    bus_read(3'd0, 16'h0004, "simul_pre");
    irq_src[2] = 1'b1;
    bus_write(3'd0, 16'h0004);
    irq_src[2] = 1'b0;
    bus_read(3'd0, 16'h0004, "simul_set_wins");
    bus_write(3'd0, 16'h0004);
    bus_read(3'd0, 16'h0000, "simul_cleared");

    // Priority among level sources 3 and 5, then masking.
    bus_write(3'd2, 16'h0000);
    bus_write(3'd1, 16'h00FF);
    irq_src[5] = 1'b1;
    irq_src[3] = 1'b1;
    step(2);
    check("prio_irq", 16'(irq), 16'h0001);
    check("prio_id_3", 16'(irq_id), 16'h0013);
    irq_src[3] = 1'b0;
    step();
    check("prio_id_hold", 16'(irq_id), 16'h0013);
    step();
    check("prio_id_5", 16'(irq_id), 16'h0015);
    bus_read(3'd3, 16'h0015, "active_id_reg");
    bus_read(3'd4, 16'h0020, "raw_reg");
    bus_write(3'd1, 16'h0000);
    check("mask_irq_t1", 16'(irq), 16'h0001);
    step();
    check("mask_irq_t2", 16'(irq), 16'h0000);
    check("mask_irq_id", 16'(irq_id), 16'h0000);
    bus_read(3'd0, 16'h0020, "masked_pending_latches");
    irq_src[5] = 1'b0;
    step(2);

    // Level->edge switch on a high source discards its pending bit.
    irq_src[4] = 1'b1;
    step(2);
    bus_read(3'd0, 16'h0010, "level_pending_b4");
    bus_write(3'd2, 16'h00FF);
    bus_read(3'd0, 16'h0000, "mode_change_clears");
    irq_src[4] = 1'b0;
    step();

    // Masked edge source 1, then enable, then SET.
    irq_src[1] = 1'b1;
    step();
    irq_src[1] = 1'b0;
    step(2);
    bus_read(3'd0, 16'h0002, "masked_edge_pending");
    check("masked_edge_irq", 16'(irq), 16'h0000);
    bus_write(3'd1, 16'h0002);
    step();
    check("enable_irq", 16'(irq), 16'h0001);
    check("enable_irq_id", 16'(irq_id), 16'h0011);
    bus_write(3'd5, 16'h0080);
    bus_read(3'd5, 16'h0000, "set_reads_zero");
    bus_read(3'd0, 16'h0082, "set_edge_bit");

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_readdata", readdata, 16'h0000);
    check("async_rst_irq", 16'(irq), 16'h0000);
    check("async_rst_irq_id", 16'(irq_id), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    step();
    bus_read(3'd1, 16'h00A5, "enable_after_reset");
    bus_read(3'd0, 16'h0000, "pending_after_reset");
    bus_read(3'd2, 16'h0000, "edge_mode_after_reset");

    check("scoreboard_empty", 16'(sb_q.size()), 16'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
